// File: rtl/rx_rs_fault_ctrl_if.sv
// rx_rs_fault_ctrl_if: XGMII 64-bit receive bus (data plus per-lane control)
interface rx_rs_fault_ctrl_if;
  logic [63:0] rxd64;
  logic [7:0]  rxc8;
  modport master (output rxd64, rxc8);
  modport slave  (input rxd64, rxc8);
endinterface

// File: rtl/rx_rs_fault_ctrl.sv
// rx_rs_fault_ctrl: RS link-fault detection, fault state machine and saturating fault-event counters
module rx_rs_fault_ctrl #(
  parameter int COL_WINDOW   = 128,
  parameter int FAULT_THRESH = 4,
  parameter int CNT_W        = 16
) (
  input  logic                 rxclk_in,
  input  logic                 reset_in,
  rx_rs_fault_ctrl_if.slave    xgmii,
  input  logic                 cfg_fault_en,
  output logic [1:0]           link_fault,
  output logic                 fault_change,
  output logic [CNT_W-1:0]     lf_event_cnt,
  output logic [CNT_W-1:0]     rf_event_cnt
);
  localparam int SW = $clog2(FAULT_THRESH + 1);
  localparam int CW = $clog2(COL_WINDOW + 1);
  typedef enum logic [1:0] {INIT, COUNT, FAULT} state_t;
  state_t           st, s;
  logic [SW-1:0]    seq_cnt, sc;
  logic [CW-1:0]    col_cnt, cc;
  logic [1:0]       last_type, lt, lf, t;
  logic [CNT_W-1:0] lc, rc;
  logic [63:0]      d_r;
  logic [7:0]       c_r;
  logic [31:0]      col;
  logic [3:0]       ctl;
  logic             is_seq;
  always_comb begin
    s = st;
    sc = seq_cnt;
    cc = col_cnt;
    lt = last_type;
    lf = link_fault;
    lc = lf_event_cnt;
    rc = rf_event_cnt;
    col = '0;
    ctl = '0;
    t = '0;
    is_seq = 1'b0;
    for (int i = 0; i < 2; i++) begin
      col = i == 0 ? d_r[63:32] : d_r[31:0];
      ctl = i == 0 ? c_r[7:4] : c_r[3:0];
      t = col[1:0];
      is_seq = ctl == 4'b1000 && col[31:8] == 24'h9c0000 && (col[7:0] == 8'h01 || col[7:0] == 8'h02);
      if (is_seq) begin
        cc = '0;
        if (s == INIT || t != lt) begin
          s = COUNT;
          lt = t;
          sc = SW'(1);
        end else if (s == COUNT) begin
          sc = sc + 1'b1;
          if (sc >= SW'(FAULT_THRESH)) begin
            s = FAULT;
            lf = t;
            lc = (t == 2'b01 && !(&lc)) ? lc + 1'b1 : lc;
            rc = (t == 2'b10 && !(&rc)) ? rc + 1'b1 : rc;
          end
        end
      end else if (s != INIT) begin
        cc = cc + 1'b1;
        if (cc == CW'(COL_WINDOW)) begin
          s = INIT;
          lf = '0;
          sc = '0;
          cc = '0;
        end
      end
    end
    if (!cfg_fault_en) begin
      s = INIT;
      lf = '0;
      sc = '0;
      cc = '0;
      lt = last_type;
      lc = lf_event_cnt;
      rc = rf_event_cnt;
    end
  end
  always_ff @(posedge rxclk_in) begin
    if (!reset_in) begin
      st <= INIT;
      seq_cnt <= '0;
      col_cnt <= '0;
      last_type <= '0;
      link_fault <= '0;
      fault_change <= 1'b0;
      lf_event_cnt <= '0;
      rf_event_cnt <= '0;
      d_r <= '0;
      c_r <= '0;
    end else begin
      st <= s;
      seq_cnt <= sc;
      col_cnt <= cc;
      last_type <= lt;
      link_fault <= lf;
      fault_change <= lf != link_fault;
      lf_event_cnt <= lc;
      rf_event_cnt <= rc;
      d_r <= xgmii.rxd64;
      c_r <= xgmii.rxc8;
    end
  end
endmodule

// File: tb/tb_rx_rs_fault_ctrl.sv
// tb_rx_rs_fault_ctrl: scoreboard bench with a column-level reference model and random traffic
module tb_rx_rs_fault_ctrl;
  localparam logic [63:0] IDLE_D = 64'h07070707_07070707;
  localparam logic [63:0] LOC_D  = 64'h9C000001_07070707;
  localparam logic [63:0] REM1_D = 64'h9C000002_07070707;
  localparam logic [63:0] REM_D  = 64'h9C000002_9C000002;
  localparam logic [63:0] BAD_D  = 64'h9C000003_9C000003;
  logic rxclk_in = 1'b0;
  logic reset_in, cfg_fault_en;
  logic [1:0] link_fault, link_fault2;
  logic fault_change, fault_change2;
  logic [15:0] lf_event_cnt, rf_event_cnt;
  logic [1:0] lf_event_cnt2, rf_event_cnt2;
  rx_rs_fault_ctrl_if bus();
  always #5 rxclk_in = ~rxclk_in;
  rx_rs_fault_ctrl dut (
    .rxclk_in(rxclk_in), .reset_in(reset_in), .xgmii(bus.slave), .cfg_fault_en(cfg_fault_en),
    .link_fault(link_fault), .fault_change(fault_change),
    .lf_event_cnt(lf_event_cnt), .rf_event_cnt(rf_event_cnt));
  rx_rs_fault_ctrl #(.CNT_W(2)) dut2 (
    .rxclk_in(rxclk_in), .reset_in(reset_in), .xgmii(bus.slave), .cfg_fault_en(cfg_fault_en),
    .link_fault(link_fault2), .fault_change(fault_change2),
    .lf_event_cnt(lf_event_cnt2), .rf_event_cnt(rf_event_cnt2));
  typedef struct {
    int lf;
    int fc;
    int lcnt;
    int rcnt;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int m_mode, m_type, m_seq, m_quiet, m_lf, m_lcnt, m_rcnt;
  logic [63:0] m_d;
  logic [7:0] m_c;
  function automatic int sat(input int v, input int mx);
    return v > mx ? mx : v;
  endfunction
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask
  // one column of the reference: mode 0 idle, 1 collecting same-type sets, 2 fault declared
  task automatic model_col(input logic [31:0] col, input logic [3:0] ctl);
    int t;
    t = 0;
    if (ctl == 4'b1000 && col[31:8] == 24'h9C0000 && (col[7:0] == 8'h01 || col[7:0] == 8'h02)) t = int'(col[7:0]);
    if (t != 0) begin
      m_quiet = 0;
      if (m_mode == 0 || t != m_type) begin
        m_type = t;
        m_seq = 1;
        m_mode = 1;
      end else if (m_mode == 1) begin
        m_seq++;
        if (m_seq >= 4) begin
          m_mode = 2;
          m_lf = t;
          if (t == 1) m_lcnt++;
          else m_rcnt++;
        end
      end
    end else if (m_mode != 0) begin
      m_quiet++;
      if (m_quiet == 128) begin
        m_mode = 0;
        m_lf = 0;
        m_seq = 0;
        m_quiet = 0;
      end
    end
  endtask
  task automatic cyc(input logic [63:0] d, input logic [7:0] c, input logic en, input logic rst_n);
    int old;
    @(negedge rxclk_in);
    bus.rxd64 = d;
    bus.rxc8 = c;
    cfg_fault_en = en;
    reset_in = rst_n;
    old = m_lf;
    if (!rst_n) begin
      m_mode = 0; m_type = 0; m_seq = 0; m_quiet = 0; m_lf = 0; m_lcnt = 0; m_rcnt = 0;
      m_d = '0;
      m_c = '0;
      q.push_back('{0, 0, 0, 0});
    end else begin
      if (en) begin
        model_col(m_d[63:32], m_c[7:4]);
        model_col(m_d[31:0], m_c[3:0]);
      end else begin
        m_mode = 0; m_lf = 0; m_seq = 0; m_quiet = 0;
      end
      m_d = d;
      m_c = c;
      q.push_back('{m_lf, int'(m_lf != old), m_lcnt, m_rcnt});
    end
  endtask
  task automatic rep(input int n, input logic [63:0] d, input logic [7:0] c);
    for (int i = 0; i < n; i++) cyc(d, c, 1'b1, 1'b1);
  endtask
  function automatic logic [35:0] rand_col(input int bias);
    int r, k;
    r = $urandom_range(0, 99);
    k = bias == 0 ? (r < 97 ? 0 : (r < 99 ? 1 : 2)) :
        bias == 1 ? (r < 80 ? 1 : (r < 90 ? 0 : (r < 95 ? 2 : 3))) :
        bias == 2 ? (r < 80 ? 2 : (r < 90 ? 0 : (r < 95 ? 1 : 3))) : r / 25;
    if (k == 0) return {4'hF, 32'h07070707};
    if (k == 1) return {4'h8, 32'h9C000001};
    if (k == 2) return {4'h8, 32'h9C000002};
    r = $urandom_range(0, 3);
    return r == 0 ? {4'h8, 32'h9C000003} : r == 1 ? {4'h0, 32'($urandom)} :
           r == 2 ? {4'hC, 32'h9C000001} : {4'h8, 32'h9C010002};
  endfunction
  initial begin
    exp_t e;
    forever begin
      @(posedge rxclk_in);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("link_fault", int'(link_fault), e.lf);
        check("fault_change", int'(fault_change), e.fc);
        check("lf_event_cnt", int'(lf_event_cnt), sat(e.lcnt, 65535));
        check("rf_event_cnt", int'(rf_event_cnt), sat(e.rcnt, 65535));
        check("link_fault_w2", int'(link_fault2), e.lf);
        check("lf_event_cnt_w2", int'(lf_event_cnt2), sat(e.lcnt, 3));
        check("rf_event_cnt_w2", int'(rf_event_cnt2), sat(e.rcnt, 3));
      end
    end
  end
  initial begin
    logic [35:0] c0, c1;
    int bias, left;
    for (int i = 0; i < 3; i++) cyc(LOC_D, 8'h8F, 1'b1, 1'b0);
    rep(4, LOC_D, 8'h8F);
    rep(63, IDLE_D, 8'hFF);
    rep(1, LOC_D, 8'h8F);
    rep(64, IDLE_D, 8'hFF);
    rep(3, LOC_D, 8'h8F);
    rep(64, IDLE_D, 8'hFF);
    rep(1, LOC_D, 8'h8F);
    rep(70, IDLE_D, 8'hFF);
    rep(4, LOC_D, 8'h8F);
    rep(5, IDLE_D, 8'hFF);
    rep(2, REM_D, 8'h88);
    rep(3, BAD_D, 8'h88);
    rep(70, IDLE_D, 8'hFF);
    for (int i = 0; i < 20; i++) cyc(i % 2 ? REM1_D : LOC_D, 8'h8F, 1'b1, 1'b1);
    rep(70, IDLE_D, 8'hFF);
    rep(2, REM_D, 8'h88);
    rep(3, IDLE_D, 8'hFF);
    cyc(IDLE_D, 8'hFF, 1'b0, 1'b1);
    cyc(IDLE_D, 8'hFF, 1'b0, 1'b1);
    rep(2, REM_D, 8'h88);
    rep(4, IDLE_D, 8'hFF);
    rep(3, LOC_D, 8'h8F);
    cyc(LOC_D, 8'h8F, 1'b1, 1'b0);
    rep(4, IDLE_D, 8'hFF);
    bias = 0;
    left = 0;
    for (int n = 0; n < 5000; n++) begin
      if (left == 0) begin
        bias = $urandom_range(0, 3);
        left = bias == 0 ? $urandom_range(20, 90) : $urandom_range(1, 12);
      end
      left--;
      c0 = rand_col(bias);
      c1 = rand_col(bias);
      cyc({c0[31:0], c1[31:0]}, {c0[35:32], c1[35:32]}, $urandom_range(0, 149) != 0, $urandom_range(0, 799) != 0);
    end
    rep(3, IDLE_D, 8'hFF);
    repeat (3) @(posedge rxclk_in);
    #2;
    check("scoreboard_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rx_rs_fault_ctrl.md
Name: rx_rs_fault_ctrl

Overview:
- Reconciliation-sublayer link-fault controller for the 10G RX path.
- Sits between the XGMII 64-bit receive bus (rxd64/rxc8) and rxReceiveEngine.
- Detects local/remote fault sequence ordered sets and runs the link-fault state machine.
- Drives the engine's link_fault input and keeps saturating fault-event counters for statistics.

Parameters:
- COL_WINDOW, 128: number of non-sequence 32-bit columns with no fault sequence that clears the fault state.
- FAULT_THRESH, 4: number of same-type fault sequences needed to declare a fault.
- CNT_W, 16: width of the fault-event counters.

Ports:
- rxclk_in  in  1  RX clock; all logic on rising edge.
- reset_in  in  1  synchronous, active-low reset.
- rxd64  in  64  XGMII data; lane0 = [63:56] … lane7 = [7:0].
- rxc8  in  8  XGMII control; rxc8[7] qualifies lane0 … rxc8[0] qualifies lane7.
- cfg_fault_en  in  1  1 = fault detection active; 0 = force INIT.
- link_fault  out  2  00 OK, 01 local fault, 10 remote fault; 11 never driven.
- fault_change  out  1  one-cycle pulse whenever link_fault changes value.
- lf_event_cnt  out  CNT_W  number of entries into local-fault state, saturating.
- rf_event_cnt  out  CNT_W  number of entries into remote-fault state, saturating.

Behaviour:
- **Reset** (reset_in=0 at an edge): state=INIT, link_fault=00, fault_change=0, seq_cnt=0, col_cnt=0, last_type=00, input registers=0, both counters=0.
- **Input stage:** rxd64/rxc8 are registered at edge E0. Decode and state update take effect at edge E1. Latency is one edge after capture (two edges after presentation).
- **Columns:** each cycle carries two columns, processed in order col0 then col1 within one update.
  - col0 = rxd64[63:32] with ctrl rxc8[7:4]; col1 = rxd64[31:0] with ctrl rxc8[3:0].
- **Fault sequence column:** ctrl nibble 1000, byte0=9C, byte1=00, byte2=00, byte3=01 (type local) or 02 (type remote).
  - Any other byte3, and every other column (idle, data, start, terminate, error), is a non-sequence column.
- **States:** INIT, COUNT, FAULT. link_fault is written only on entry to INIT (00) or FAULT (type); COUNT holds the current value.
- **Fault sequence of type T, from INIT:** last_type=T, seq_cnt=1, col_cnt=0, go to COUNT.
- **Fault sequence of type T, from COUNT:**
  - T==last_type: seq_cnt+1, col_cnt=0. If the new seq_cnt ≥ FAULT_THRESH, go to FAULT, link_fault=T, increment that type's counter.
  - T!=last_type: last_type=T, seq_cnt=1, col_cnt=0.
- **Fault sequence of type T, from FAULT:**
  - T==last_type: col_cnt=0, stay.
  - T!=last_type: go to COUNT with last_type=T, seq_cnt=1, col_cnt=0. link_fault is held.
- **Non-sequence column** in COUNT or FAULT: col_cnt+1. When col_cnt reaches COL_WINDOW: go to INIT, link_fault=00, seq_cnt=0, col_cnt=0. In INIT, no counting.
- **Threshold chaining:** a threshold crossing on col0 followed by a different-type sequence on col1 is evaluated in order: FAULT is entered for col0 (counter increments), then COUNT is entered for col1.
- **cfg_fault_en=0:** at each edge, state=INIT and link_fault=00. Column decode is ignored; counters hold. If link_fault was nonzero, fault_change pulses.
- **Counters:**
  - Saturate at all ones; no wrap.
  - Increment exactly once per FAULT entry.
  - Re-entering FAULT from COUNT with the same type counts again.
- **fault_change:** asserted for exactly one cycle in the cycle where the registered link_fault differs from its previous value. Never asserted by reset.
- **Reset mid-operation:** reset overrides everything at that edge, including a pending threshold crossing.

Test Plan:
- **Reset:** hold reset_in=0 three cycles with fault sequences on the bus -> link_fault=00, fault_change=0, both counters 0.
- **Local fault declared:** rxd64=9C000001_07070707, rxc8=8F for 4 consecutive cycles, then idles (0707…, FF) -> link_fault=01 from the second edge after the 4th set; fault_change high one cycle; lf_event_cnt=1; link_fault stays 01 while idles last ≤63 cycles.
- **Window clears sub-threshold count:** 3 local sets, then 64 idle cycles (128 columns), then 1 local set -> link_fault stays 00 throughout, counters 0.
- **Fault clears on window:** after a local fault, 64 idle cycles -> link_fault=00 at the edge the 128th column is processed; fault_change pulses. 63 idle cycles plus a local set -> remains 01.
- **Remote sets, two per cycle:** while in local fault, rxd64=9C000002_9C000002, rxc8=88 for 2 cycles -> link_fault 01 until the 4th remote column, then 10; rf_event_cnt=1; lf_event_cnt unchanged. Byte3=03 sequences are counted as idles.
- **Enable and alternating types:** alternating local/remote sets for 20 cycles -> link_fault 00 throughout. Separately, in remote fault drop cfg_fault_en -> link_fault=00 at the next edge with a fault_change pulse; re-enable with 4 remote sets -> rf_event_cnt=2.
